// File: rtl/readout_sequencer.sv
// readout_sequencer
// Row-readout stage of the pixel-array control path. A one-cycle start pulse
// (accepted only in IDLE) launches a pass over every row. Each row is selected
// for SETTLE_CYC cycles with the ADC held in reset, then for CONV_CYC cycles
// with the ADC counter enabled, then for one strobe cycle that marks the
// row's result as stable. After the last row a one-cycle done pulse is issued.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   start        one-cycle launch pulse, sampled only in IDLE
//   row_sel      one-hot row select (bit i = row i)
//   read         pixel read enable, high while any row is selected
//   adc_reset    ADC counter held in reset (settle window)
//   adc_count_en ADC counter enable (conversion window)
//   data_valid   one-cycle strobe, current row's ADC result is stable
//   row_idx      index of the row being read
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last row completes
//
// All outputs are registered and decoded from the next state, so they line up
// with the state they describe and have no combinational path from start.
module readout_sequencer #(
    parameter int ROWS       = 2,
    parameter int ROW_W      = 1,
    parameter int SETTLE_CYC = 2,
    parameter int CONV_CYC   = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [ROWS-1:0]  row_sel,
    output logic             read,
    output logic             adc_reset,
    output logic             adc_count_en,
    output logic             data_valid,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CONVERT = 3'd2,
        ST_STROBE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [ROWS-1:0]  SEL_ONE     = ROWS'(1);

    state_t           state_r;
    state_t           state_s;
    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // Next-state, row counter and cycle counter. The cycle counter clears on
    // every window change, so it never runs past its terminal value.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SETTLE;
                    row_s   = {ROW_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_CONVERT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (cnt_r == CONV_LAST) begin
                    state_s = ST_STROBE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (row_r == ROW_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SETTLE;
                    row_s   = row_r + ROW_W'(1);
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                row_s   = {ROW_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                row_s   = {ROW_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State/counter registers and Moore outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            row_r        <= {ROW_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            row_sel      <= {ROWS{1'b0}};
            read         <= 1'b0;
            adc_reset    <= 1'b0;
            adc_count_en <= 1'b0;
            data_valid   <= 1'b0;
            row_idx      <= {ROW_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            cnt_r        <= cnt_s;
            row_sel      <= {ROWS{1'b0}};
            read         <= 1'b0;
            adc_reset    <= 1'b0;
            adc_count_en <= 1'b0;
            data_valid   <= 1'b0;
            row_idx      <= {ROW_W{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            case (state_s)
                ST_SETTLE: begin
                    row_sel   <= SEL_ONE << row_s;
                    read      <= 1'b1;
                    adc_reset <= 1'b1;
                    row_idx   <= row_s;
                    busy      <= 1'b1;
                end
                ST_CONVERT: begin
                    row_sel      <= SEL_ONE << row_s;
                    read         <= 1'b1;
                    adc_count_en <= 1'b1;
                    row_idx      <= row_s;
                    busy         <= 1'b1;
                end
                ST_STROBE: begin
                    row_sel    <= SEL_ONE << row_s;
                    read       <= 1'b1;
                    data_valid <= 1'b1;
                    row_idx    <= row_s;
                    busy       <= 1'b1;
                end
                ST_DONE: begin
                    busy <= 1'b1;
                    done <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: default instance (2 rows, 2 settle,
// 4 convert) and a ROWS=1/SETTLE_CYC=1/CONV_CYC=1 instance.
// Output vector layout: {row_sel[1:0], read, adc_reset, adc_count_en,
//                        data_valid, row_idx, busy, done}
module tb_readout_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_a;
    logic       start_b;

    logic [1:0] row_sel_a;
    logic       read_a, adc_reset_a, adc_count_en_a, data_valid_a;
    logic [0:0] row_idx_a;
    logic       busy_a, done_a;

    logic [0:0] row_sel_b;
    logic       read_b, adc_reset_b, adc_count_en_b, data_valid_b;
    logic [0:0] row_idx_b;
    logic       busy_b, done_b;

    int checks = 0;
    int errors = 0;

    readout_sequencer #(
        .ROWS(2), .ROW_W(1), .SETTLE_CYC(2), .CONV_CYC(4), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .row_sel(row_sel_a), .read(read_a), .adc_reset(adc_reset_a),
        .adc_count_en(adc_count_en_a), .data_valid(data_valid_a),
        .row_idx(row_idx_a), .busy(busy_a), .done(done_a)
    );

    readout_sequencer #(
        .ROWS(1), .ROW_W(1), .SETTLE_CYC(1), .CONV_CYC(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .row_sel(row_sel_b), .read(read_b), .adc_reset(adc_reset_b),
        .adc_count_en(adc_count_en_b), .data_valid(data_valid_b),
        .row_idx(row_idx_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] obs_a();
        return {row_sel_a, read_a, adc_reset_a, adc_count_en_a,
                data_valid_a, row_idx_a, busy_a, done_a};
    endfunction

    function automatic logic [8:0] obs_b();
        return {1'b0, row_sel_b, read_b, adc_reset_b, adc_count_en_b,
                data_valid_b, row_idx_b, busy_b, done_b};
    endfunction

    // Expected default-instance outputs in cycle k after the start-sampling
    // edge: rows of 7 cycles (2 settle, 4 convert, 1 strobe), done in 15.
    function automatic logic [8:0] exp_nom(input int k);
        logic [8:0] e;
        int r;
        int p;
        e = 9'd0;
        if (k >= 1 && k <= 14) begin
            r = (k - 1) / 7;
            p = (k - 1) % 7;
            e[8:7] = (r == 0) ? 2'b01 : 2'b10;
            e[6]   = 1'b1;
            e[5]   = (p < 2);
            e[4]   = (p >= 2 && p < 6);
            e[3]   = (p == 6);
            e[2]   = (r == 1);
            e[1]   = 1'b1;
        end else if (k == 15) begin
            e[1] = 1'b1;
            e[0] = 1'b1;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        checks++;
        assert ($onehot0(row_sel_a) && !(adc_reset_a && adc_count_en_a) &&
                $onehot0(row_sel_b) && !(adc_reset_b && adc_count_en_b)) else begin
            errors++;
            $error("FAIL %s_invariant observed a=%b b=%b expected onehot0/exclusive",
                   tag, obs_a(), obs_b());
        end
    endtask

    // Expects start_a already set for edge 0. Observes cycles 1..16; extra
    // start pulses are raised during cycles e1/e2; chain leaves start high in
    // cycle 16 so the next call launches from that edge.
    task automatic run(input string tag, input int e1, input int e2, input bit chain);
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("%s_c%0d", tag, k), obs_a(), exp_nom(k));
            start_a = (k == e1) || (k == e2) || (chain && k == 16);
            if (k < 16) tick();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;

        // Reset then idle
        tick();
        chk("rst_a", obs_a(), 9'd0);
        chk("rst_b", obs_b(), 9'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("idle_a_%0d", i), obs_a(), 9'd0);
            chk($sformatf("idle_b_%0d", i), obs_b(), 9'd0);
        end

        // Nominal run
        start_a = 1'b1;
        run("nom", 0, 0, 1'b0);

        // Start while busy (CONVERT and DONE), then start in first IDLE cycle
        tick();
        start_a = 1'b1;
        run("busy", 3, 15, 1'b1);
        run("chain", 0, 0, 1'b0);

        // Reset in row 0 CONVERT (cycle 5)
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("pre_rst_c%0d", k), obs_a(), exp_nom(k));
            if (k < 5) tick();
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_c6", obs_a(), 9'd0);
        rst_n = 1'b1;
        for (int k = 7; k <= 18; k++) begin
            tick();
            chk($sformatf("post_rst_c%0d", k), obs_a(), 9'd0);
        end
        start_a = 1'b1;
        run("after_rst", 0, 0, 1'b0);

        // Single-row variant
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("v1_c1", obs_b(), 9'b0_1_1_1_0_0_0_1_0);
        tick();
        chk("v1_c2", obs_b(), 9'b0_1_1_0_1_0_0_1_0);
        tick();
        chk("v1_c3", obs_b(), 9'b0_1_1_0_0_1_0_1_0);
        tick();
        chk("v1_c4", obs_b(), 9'b0_0_0_0_0_0_0_1_1);
        tick();
        chk("v1_c5", obs_b(), 9'd0);
        chk("v1_a_idle", obs_a(), 9'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
